dbg_pipe_ctrl: RTL and testbench

- Debug-mode pipeline controller for the 3-stage core (IF, EX, MW). It sits between the external debug module, the hazard unit and the pipeline registers.
- It combines hazard stall and branch flush with debugger halt, resume, single-step and ebreak.
- It owns the DPC and DCSR.cause registers.
- It generates the final fetch-stall, EX-flush and fetch-redirect controls.

---
 rtl/dbg_pkg.sv | 18 +
 rtl/dbg_pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_dbg_pipe_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared state encoding and dcsr.cause values for the debug-mode pipeline controller.
package dbg_pkg;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_HALTED = 3'd2,
      ST_RESUME = 3'd3,
      ST_STEP_F = 3'd4,
      ST_STEP_X = 3'd5
   } dbg_state_e;

   localparam logic [2:0] CAUSE_NONE    = 3'd0;
   localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
   localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
   localparam logic [2:0] CAUSE_STEP    = 3'd4;

endpackage

// File: rtl/dbg_pipe_ctrl.sv
// Debug-mode pipeline controller: merges hazard stall / branch flush with debugger
// halt, resume, single-step and ebreak, and owns DPC and DCSR.cause.
module dbg_pipe_ctrl
   import dbg_pkg::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter bit          HALT_ON_RESET = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            haltreq,
   input  logic            resumereq,
   input  logic            step,
   input  logic            ebreak_ex,
   input  logic            ex_valid,
   input  logic            hz_stall,
   input  logic            br_taken,
   input  logic [XLEN-1:0] pc_ex,
   input  logic [XLEN-1:0] npc_mw,
   input  logic            dpc_we,
   input  logic [XLEN-1:0] dpc_wdata,
   output logic            stall_if,
   output logic            flush_ex,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            halted,
   output logic            resumeack,
   output logic [2:0]      cause,
   output logic [XLEN-1:0] dpc
);

   dbg_state_e      state_q, state_d;
   logic [XLEN-1:0] dpc_q, dpc_d;
   logic [2:0]      cause_q, cause_d;
   logic            step_q, step_d;
   // Set when a single-stepped instruction reached MW; DRAIN then latches its npc_mw.
   logic            cap_q, cap_d;

   logic ebreak_hit;
   assign ebreak_hit = ebreak_ex & ex_valid;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values computed by the combinational block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HALT_ON_RESET ? ST_HALTED : ST_RUN;
         dpc_q   <= '0;
         cause_q <= HALT_ON_RESET ? CAUSE_HALTREQ : CAUSE_NONE;
         step_q  <= 1'b0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dpc_q   <= dpc_d;
         cause_q <= cause_d;
         step_q  <= step_d;
         cap_q   <= cap_d;
      end
   end

   always_comb begin
      // NOTE: every output and next-state variable gets a default first, so no path
      // through the case statement can infer a latch.
      state_d   = state_q;
      dpc_d     = dpc_q;
      cause_d   = cause_q;
      step_d    = step_q;
      cap_d     = 1'b0;
      stall_if  = 1'b0;
      flush_ex  = 1'b0;
      redirect  = 1'b0;
      resumeack = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            stall_if = hz_stall;
            flush_ex = br_taken | hz_stall;
            if (ebreak_hit) begin
               stall_if = 1'b1;
               flush_ex = 1'b1;
               dpc_d    = pc_ex;
               cause_d  = CAUSE_EBREAK;
               state_d  = ST_DRAIN;
            end else if (haltreq) begin
               // MW retires; a taken branch there means EX is on the wrong path.
               stall_if = 1'b1;
               flush_ex = 1'b1;
               dpc_d    = br_taken ? npc_mw : pc_ex;
               cause_d  = CAUSE_HALTREQ;
               state_d  = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            stall_if = 1'b1;
            flush_ex = 1'b1;
            if (cap_q) dpc_d = npc_mw;
            state_d = ST_HALTED;
         end

         ST_HALTED: begin
            stall_if = 1'b1;
            flush_ex = 1'b1;
            if (dpc_we) dpc_d = dpc_wdata;
            if (resumereq) begin
               step_d  = step;
               state_d = ST_RESUME;
            end
         end

         ST_RESUME: begin
            redirect  = 1'b1;
            resumeack = 1'b1;
            flush_ex  = 1'b1;
            state_d   = step_q ? ST_STEP_F : ST_RUN;
         end

         ST_STEP_F: begin
            state_d = ST_STEP_X;
         end

         ST_STEP_X: begin
            stall_if = 1'b1;
            flush_ex = hz_stall;
            if (ebreak_hit) begin
               flush_ex = 1'b1;
               dpc_d    = pc_ex;
               cause_d  = CAUSE_EBREAK;
               state_d  = ST_DRAIN;
            end else if (ex_valid && !hz_stall) begin
               cause_d = haltreq ? CAUSE_HALTREQ : CAUSE_STEP;
               cap_d   = 1'b1;
               state_d = ST_DRAIN;
            end
         end

         default: state_d = ST_RUN;
      endcase
   end

   assign halted      = (state_q == ST_HALTED);
   assign dpc         = dpc_q;
   assign redirect_pc = dpc_q;
   assign cause       = cause_q;

endmodule

// File: tb/tb_dbg_pipe_ctrl.sv
// Self-checking bench for dbg_pipe_ctrl: directed debug scenarios followed by
// randomized traffic, all compared against a phase-flag reference model.
module tb_dbg_pipe_ctrl;
   import dbg_pkg::*;

   localparam int XLEN = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, haltreq, resumereq, step, ebreak_ex, ex_valid, hz_stall, br_taken, dpc_we;
   logic [XLEN-1:0] pc_ex, npc_mw, dpc_wdata;

   logic            stall_if, flush_ex, redirect, halted, resumeack;
   logic [XLEN-1:0] redirect_pc, dpc;
   logic [2:0]      cause;

   logic            h_stall_if, h_flush_ex, h_redirect, h_halted, h_resumeack;
   logic [XLEN-1:0] h_redirect_pc, h_dpc;
   logic [2:0]      h_cause;

   dbg_pipe_ctrl #(.XLEN(XLEN), .HALT_ON_RESET(1'b0)) u_dut (
      .clk(clk), .rst(rst), .haltreq(haltreq), .resumereq(resumereq), .step(step),
      .ebreak_ex(ebreak_ex), .ex_valid(ex_valid), .hz_stall(hz_stall), .br_taken(br_taken),
      .pc_ex(pc_ex), .npc_mw(npc_mw), .dpc_we(dpc_we), .dpc_wdata(dpc_wdata),
      .stall_if(stall_if), .flush_ex(flush_ex), .redirect(redirect), .redirect_pc(redirect_pc),
      .halted(halted), .resumeack(resumeack), .cause(cause), .dpc(dpc)
   );

   dbg_pipe_ctrl #(.XLEN(XLEN), .HALT_ON_RESET(1'b1)) u_dut_hor (
      .clk(clk), .rst(rst), .haltreq(haltreq), .resumereq(resumereq), .step(step),
      .ebreak_ex(ebreak_ex), .ex_valid(ex_valid), .hz_stall(hz_stall), .br_taken(br_taken),
      .pc_ex(pc_ex), .npc_mw(npc_mw), .dpc_we(dpc_we), .dpc_wdata(dpc_wdata),
      .stall_if(h_stall_if), .flush_ex(h_flush_ex), .redirect(h_redirect), .redirect_pc(h_redirect_pc),
      .halted(h_halted), .resumeack(h_resumeack), .cause(h_cause), .dpc(h_dpc)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: where the core is in its debug life cycle, as independent flags.
   bit              m_drain, m_halted, m_resume, m_fetch, m_wait, m_cap, m_step;
   logic [XLEN-1:0] m_dpc;
   logic [2:0]      m_cause;

   task automatic model_reset();
      {m_drain, m_halted, m_resume, m_fetch, m_wait, m_cap, m_step} = '0;
      m_dpc   = '0;
      m_cause = 3'd0;
   endtask

   task automatic idle();
      rst = 1'b0; haltreq = 1'b0; resumereq = 1'b0; step = 1'b0; ebreak_ex = 1'b0;
      ex_valid = 1'b0; hz_stall = 1'b0; br_taken = 1'b0; dpc_we = 1'b0;
      pc_ex = '0; npc_mw = '0; dpc_wdata = '0;
   endtask

   // Called at a negedge with inputs applied: checks outputs, advances the model, steps one clock.
   task automatic cycle();
      bit   run, eb, adv, stop;
      logic e_stall, e_flush;
      #1;
      run  = !(m_drain || m_halted || m_resume || m_fetch || m_wait);
      eb   = ebreak_ex && ex_valid;
      adv  = m_wait && ex_valid && !hz_stall;
      stop = (run && (eb || haltreq)) || (m_wait && (eb || adv));
      if (run) begin
         e_stall = stop | hz_stall;
         e_flush = stop | br_taken | hz_stall;
      end else if (m_drain || m_halted) begin
         e_stall = 1'b1; e_flush = 1'b1;
      end else if (m_resume) begin
         e_stall = 1'b0; e_flush = 1'b1;
      end else if (m_fetch) begin
         e_stall = 1'b0; e_flush = 1'b0;
      end else begin
         e_stall = 1'b1; e_flush = eb | hz_stall;
      end

      check("stall_if",    32'(stall_if),  32'(e_stall));
      check("flush_ex",    32'(flush_ex),  32'(e_flush));
      check("redirect",    32'(redirect),  32'(m_resume));
      check("resumeack",   32'(resumeack), 32'(m_resume));
      check("halted",      32'(halted),    32'(m_halted));
      check("cause",       32'(cause),     32'(m_cause));
      check("dpc",         dpc,            m_dpc);
      check("redirect_pc", redirect_pc,    m_dpc);
      check("redir_and_stall", 32'(redirect & stall_if), 32'd0);

      if (rst) begin
         model_reset();
      end else if (run) begin
         if (eb) begin
            m_dpc = pc_ex; m_cause = CAUSE_EBREAK; m_drain = 1'b1;
         end else if (haltreq) begin
            m_dpc = br_taken ? npc_mw : pc_ex; m_cause = CAUSE_HALTREQ; m_drain = 1'b1;
         end
      end else if (m_drain) begin
         if (m_cap) m_dpc = npc_mw;
         m_cap = 1'b0; m_drain = 1'b0; m_halted = 1'b1;
      end else if (m_halted) begin
         if (dpc_we) m_dpc = dpc_wdata;
         if (resumereq) begin
            m_halted = 1'b0; m_resume = 1'b1; m_step = step;
         end
      end else if (m_resume) begin
         m_resume = 1'b0;
         m_fetch  = m_step;
      end else if (m_fetch) begin
         m_fetch = 1'b0; m_wait = 1'b1;
      end else if (m_wait) begin
         if (eb) begin
            m_dpc = pc_ex; m_cause = CAUSE_EBREAK; m_wait = 1'b0; m_drain = 1'b1;
         end else if (adv) begin
            m_cause = haltreq ? CAUSE_HALTREQ : CAUSE_STEP;
            m_cap = 1'b1; m_wait = 1'b0; m_drain = 1'b1;
         end
      end

      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cycle();
      idle();
      check("rst_dpc",       dpc,                 32'h0);
      check("rst_cause",     32'(cause),          32'd0);
      check("rst_halted",    32'(halted),         32'd0);
      check("rst_stall",     32'(stall_if),       32'd0);
      check("rst_flush",     32'(flush_ex),       32'd0);
      check("rst_redirect",  32'(redirect),       32'd0);
      check("hor_halted",    32'(h_halted),       32'd1);
      check("hor_cause",     32'(h_cause),        32'(CAUSE_HALTREQ));
      check("hor_dpc",       h_dpc,               32'h0);
      check("hor_redir_pc",  h_redirect_pc,       32'h0);
      check("hor_stall",     32'(h_stall_if),     32'd1);
      check("hor_flush",     32'(h_flush_ex),     32'd1);
      check("hor_redirect",  32'(h_redirect),     32'd0);
      check("hor_resumeack", 32'(h_resumeack),    32'd0);
   endtask

   task automatic step_test(input bit with_stall);
      idle();
      dpc_we = 1'b1; dpc_wdata = 32'h80; resumereq = 1'b1; step = 1'b1;
      cycle();
      idle();
      check("step_redir_pc", redirect_pc, 32'h80);
      cycle();
      cycle();
      pc_ex = 32'h80; ex_valid = 1'b1;
      if (with_stall) begin
         hz_stall = 1'b1;
         cycle();
         check("step_stall_hold", 32'(halted), 32'd0);
         hz_stall = 1'b0;
      end
      cycle();
      idle();
      npc_mw = 32'h84;
      cycle();
      idle();
      check("step_halted", 32'(halted), 32'd1);
      check("step_cause",  32'(cause),  32'(CAUSE_STEP));
      check("step_dpc",    dpc,         32'h84);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      do_reset();

      // Stray resume while running.
      resumereq = 1'b1;
      cycle();
      idle();
      check("stray_ack", 32'(resumeack), 32'd0);

      // Halt while running.
      pc_ex = 32'h40; haltreq = 1'b1;
      cycle();
      check("halt_lat1", 32'(halted), 32'd0);
      cycle();
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_dpc",    dpc,         32'h40);
      check("halt_cause",  32'(cause),  32'(CAUSE_HALTREQ));

      // Resume with DPC write in the same cycle; haltreq still high.
      dpc_we = 1'b1; dpc_wdata = 32'h200; resumereq = 1'b1;
      cycle();
      idle();
      check("res_redirect",  32'(redirect),  32'd1);
      check("res_redir_pc",  redirect_pc,    32'h200);
      check("res_ack",       32'(resumeack), 32'd1);
      cycle();
      check("res_ack_once",  32'(resumeack), 32'd0);

      // Halt under a taken branch.
      haltreq = 1'b1; br_taken = 1'b1; npc_mw = 32'h100; pc_ex = 32'h44;
      cycle();
      idle();
      haltreq = 1'b1;
      cycle();
      idle();
      check("br_halted", 32'(halted), 32'd1);
      check("br_dpc",    dpc,         32'h100);

      step_test(1'b0);
      step_test(1'b1);

      // ebreak beats haltreq.
      resumereq = 1'b1;
      cycle();
      idle();
      cycle();
      ebreak_ex = 1'b1; ex_valid = 1'b1; pc_ex = 32'h60; haltreq = 1'b1;
      cycle();
      idle();
      haltreq = 1'b1;
      cycle();
      idle();
      check("eb_cause", 32'(cause), 32'(CAUSE_EBREAK));
      check("eb_dpc",   dpc,        32'h60);

      // Reset while waiting in the step-execute phase.
      resumereq = 1'b1; step = 1'b1;
      cycle();
      idle();
      cycle();
      cycle();
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         rst       = ($urandom_range(0, 399) == 0);
         haltreq   = ($urandom_range(0, 11) == 0);
         resumereq = ($urandom_range(0, 3) == 0);
         step      = $urandom_range(0, 1) == 1;
         ebreak_ex = ($urandom_range(0, 19) == 0);
         ex_valid  = $urandom_range(0, 1) == 1;
         hz_stall  = ($urandom_range(0, 4) == 0);
         br_taken  = ($urandom_range(0, 4) == 0);
         dpc_we    = ($urandom_range(0, 2) == 0);
         pc_ex     = $urandom;
         npc_mw    = $urandom;
         dpc_wdata = $urandom;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
